// File: rtl/lamp_sequencer_pkg.sv
// lamp_sequencer_pkg
// Shared types and constants for the lamp sequencer:
//   - state_e          : sequencer states (IDLE, ON, GAP)
//   - DEF_*            : default timing/size constants (25 MHz board, 1 ms tick)
//   - TONE_HALF_PERIOD : per-lamp tone half-period in clocks, and a lookup
//                        helper that is safe for indices beyond the table.
//                        Only used when LAMP_SEQUENCER_TONE_EN is defined.
package lamp_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int unsigned DEF_NUM_LAMPS     = 4;
    localparam int unsigned DEF_CLKS_PER_TICK = 25000;
    localparam int unsigned DEF_DUR_W         = 8;
    localparam int unsigned DEF_GAP_TICKS     = 50;

    localparam int unsigned TONE_TABLE_LEN = 8;
    localparam logic [15:0] TONE_HALF_PERIOD [TONE_TABLE_LEN] = '{
        16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9
    };

    // Table lookup; indices past the table map to 0 (tone disabled).
    function automatic logic [15:0] tone_half(input logic [31:0] idx);
        logic [15:0] half;
        if (idx < TONE_TABLE_LEN) begin
            half = TONE_HALF_PERIOD[idx];
        end else begin
            half = 16'd0;
        end
        return half;
    endfunction

endpackage

// File: rtl/lamp_sequencer_if.sv
// lamp_sequencer_if
// Command handshake and lamp-drive bundle between the game-control FSM
// (master) and the lamp sequencer (slave).
//   i_Valid/o_Ready : command handshake, i_Lamp/i_Dur captured on accept
//   o_Lamps         : one-hot lamp drive
//   o_Busy/o_Done   : sequencer activity and end-of-gap pulse
//   o_Tone          : tone output, present only with LAMP_SEQUENCER_TONE_EN
interface lamp_sequencer_if
    import lamp_sequencer_pkg::*;
#(
    parameter int unsigned NUM_LAMPS = DEF_NUM_LAMPS,
    parameter int unsigned DUR_W     = DEF_DUR_W
);
    localparam int unsigned LAMP_W = (NUM_LAMPS > 1) ? $clog2(NUM_LAMPS) : 1;

    logic                 i_Valid;
    logic                 o_Ready;
    logic [LAMP_W-1:0]    i_Lamp;
    logic [DUR_W-1:0]     i_Dur;
    logic [NUM_LAMPS-1:0] o_Lamps;
    logic                 o_Busy;
    logic                 o_Done;
`ifdef LAMP_SEQUENCER_TONE_EN
    logic                 o_Tone;

    modport master (output i_Valid, i_Lamp, i_Dur,
                    input  o_Ready, o_Lamps, o_Busy, o_Done, o_Tone);
    modport slave  (input  i_Valid, i_Lamp, i_Dur,
                    output o_Ready, o_Lamps, o_Busy, o_Done, o_Tone);
`else
    modport master (output i_Valid, i_Lamp, i_Dur,
                    input  o_Ready, o_Lamps, o_Busy, o_Done);
    modport slave  (input  i_Valid, i_Lamp, i_Dur,
                    output o_Ready, o_Lamps, o_Busy, o_Done);
`endif

endinterface

// File: rtl/lamp_sequencer_tick_prescaler.sv
// tick_prescaler
// Divides i_Clk into a one-cycle o_Tick strobe every CLKS_PER_TICK clocks.
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   i_Clr          : synchronous clear; the count restarts at 0 next cycle
//   o_Tick         : high during the last clock of each tick period
module tick_prescaler
    import lamp_sequencer_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = DEF_CLKS_PER_TICK
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Clr,
    output logic o_Tick
);
    localparam int unsigned CNT_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_TICK - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: cleared on request or at the terminal value, never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (i_Clr) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Tick = (cnt_q == CNT_LAST) && !i_Clr;

endmodule

// File: rtl/lamp_sequencer.sv
// lamp_sequencer
// Accepts lamp-flash commands over a valid/ready handshake and drives a
// registered, glitch-free one-hot lamp output: the lamp is lit for
// i_Dur ticks, then a fixed GAP_TICKS dark gap is enforced before the next
// command. o_Done pulses as the gap ends, together with o_Ready returning.
// Ports:
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset (deassertion is
//                    re-synchronised internally)
//   bus (slave)    : i_Valid/o_Ready/i_Lamp/i_Dur, o_Lamps, o_Busy, o_Done
// Optional: define LAMP_SEQUENCER_TONE_EN to add bus.o_Tone, a square wave
// during ON whose half period comes from TONE_HALF_PERIOD[lamp].
module lamp_sequencer
    import lamp_sequencer_pkg::*;
#(
    parameter int unsigned NUM_LAMPS     = DEF_NUM_LAMPS,
    parameter int unsigned CLKS_PER_TICK = DEF_CLKS_PER_TICK,
    parameter int unsigned DUR_W         = DEF_DUR_W,
    parameter int unsigned GAP_TICKS     = DEF_GAP_TICKS
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    lamp_sequencer_if.slave  bus
);
    localparam int unsigned LAMP_W = (NUM_LAMPS > 1) ? $clog2(NUM_LAMPS) : 1;
    localparam int unsigned GAP_W  = $clog2(GAP_TICKS + 1);
    localparam int unsigned TICK_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam logic [TICK_W-1:0] GAP_LAST = TICK_W'(GAP_TICKS - 1);

    logic [1:0]           rst_sync_q;
    logic                 rst_n_s;
    state_e               state_q;
    logic [TICK_W-1:0]    tick_q;
    logic [DUR_W-1:0]     dur_q;
    logic [NUM_LAMPS-1:0] lamps_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic [NUM_LAMPS-1:0] lamp_dec_s;
    logic [TICK_W-1:0]    dur_last_s;
    logic                 accept_s;
    logic                 tick_s;
    logic                 on_end_s;
    logic                 gap_end_s;

    // Reset synchroniser: asserts asynchronously, releases on a clock edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_q[1];

    // Lamp index decode; an out-of-range index matches no bit and stays dark.
    always_comb begin
        lamp_dec_s = '0;
        for (int i = 0; i < int'(NUM_LAMPS); i++) begin
            lamp_dec_s[i] = (bus.i_Lamp == LAMP_W'(i));
        end
    end

    // ready_q is only set in IDLE, so this is the accept condition.
    assign accept_s   = bus.i_Valid && ready_q;
    assign dur_last_s = TICK_W'(dur_q) - TICK_W'(1);
    assign on_end_s   = (state_q == ON)  && tick_s && (tick_q == dur_last_s);
    assign gap_end_s  = (state_q == GAP) && tick_s && (tick_q == GAP_LAST);

    // Held in clear while idle so the first ON/GAP tick is a full period.
    tick_prescaler #(
        .CLKS_PER_TICK (CLKS_PER_TICK)
    ) u_prescaler (
        .i_Clk   (i_Clk),
        .i_Rst_L (rst_n_s),
        .i_Clr   (state_q == IDLE),
        .o_Tick  (tick_s)
    );

    // Sequencer FSM with registered lamp/handshake/status outputs.
    always_ff @(posedge i_Clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q <= IDLE;
            tick_q  <= '0;
            dur_q   <= '0;
            lamps_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        dur_q   <= bus.i_Dur;
                        tick_q  <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (bus.i_Dur != '0) begin
                            state_q <= ON;
                            lamps_q <= lamp_dec_s;
                        end else begin
                            state_q <= GAP;
                            lamps_q <= '0;
                        end
                    end
                end
                ON: begin
                    if (on_end_s) begin
                        state_q <= GAP;
                        tick_q  <= '0;
                        lamps_q <= '0;
                    end else if (tick_s) begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end
                GAP: begin
                    if (gap_end_s) begin
                        state_q <= IDLE;
                        tick_q  <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (tick_s) begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tick_q  <= '0;
                    lamps_q <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Lamps = lamps_q;
    assign bus.o_Ready = ready_q;
    assign bus.o_Busy  = busy_q;
    assign bus.o_Done  = done_q;

`ifdef LAMP_SEQUENCER_TONE_EN
    logic [15:0] tone_half_q;
    logic [15:0] tone_cnt_q;
    logic        tone_ok_q;
    logic        tone_q;

    // Tone generator: restarts on accept, runs only while ON with a valid lamp.
    always_ff @(posedge i_Clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            tone_half_q <= 16'd0;
            tone_cnt_q  <= 16'd0;
            tone_ok_q   <= 1'b0;
            tone_q      <= 1'b0;
        end else if ((state_q == IDLE) && accept_s) begin
            tone_half_q <= tone_half(32'(bus.i_Lamp));
            tone_cnt_q  <= 16'd0;
            tone_ok_q   <= (|lamp_dec_s) && (tone_half(32'(bus.i_Lamp)) != 16'd0);
            tone_q      <= 1'b0;
        end else if ((state_q == ON) && tone_ok_q && !on_end_s) begin
            if (tone_cnt_q == (tone_half_q - 16'd1)) begin
                tone_cnt_q <= 16'd0;
                tone_q     <= ~tone_q;
            end else begin
                tone_cnt_q <= tone_cnt_q + 16'd1;
            end
        end else begin
            tone_cnt_q <= 16'd0;
            tone_q     <= 1'b0;
        end
    end

    assign bus.o_Tone = tone_q;
`endif

endmodule
